// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the frame-pipeline sequencer.
// state        | meaning
// ST_IDLE      | no frame in flight, waiting for run/single
// ST_WAIT_SYNC | selected stage waits for a vsync falling edge
// ST_START     | one-cycle start pulse to the selected stage
// ST_RUN       | stage busy; watch its done bit and the watchdog
// ST_ERROR     | watchdog expired; held until clear_err
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_ERROR     = 3'd4
  } seq_state_e;

  localparam int TMR_W = 24;

endpackage

// File: rtl/pipeline_sequencer_vsync.sv
// Brings the active-low vertical sync into clk and flags its falling edge.
// The flops reset high so releasing reset never looks like a sync edge.
module vsync_edge_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sync_n,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_sync_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/pipeline_sequencer.sv
// Frame-pipeline sequencer: walks the enabled stages through start/done handshakes
// with optional vsync gating per stage, a run watchdog and a frame counter.
module pipeline_sequencer
  import seq_pkg::*;
#(
  parameter int                    NUM_STAGES     = 4,
  parameter logic [NUM_STAGES-1:0] SYNC_MASK      = 4'b1000,
  parameter logic [TMR_W-1:0]      TIMEOUT_CYCLES = 24'd12_000_000,
  parameter int                    CNT_W          = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_run,
  input  logic                          i_single,
  input  logic                          i_clear_err,
  input  logic [NUM_STAGES-1:0]         i_stage_enable,
  input  logic                          i_frame_sync,
  input  logic [NUM_STAGES-1:0]         i_stage_done,
  output logic [NUM_STAGES-1:0]         o_stage_start,
  output logic [$clog2(NUM_STAGES)-1:0] o_stage_idx,
  output logic [2:0]                    o_state,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic [CNT_W-1:0]              o_frame_count,
  output logic                          o_timeout_err,
  output logic [$clog2(NUM_STAGES)-1:0] o_err_stage
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  seq_state_e            r_state;
  logic [NUM_STAGES-1:0] r_enable;
  logic [NUM_STAGES-1:0] r_stage_start;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_err_stage;
  logic [TMR_W-1:0]      r_timer;
  logic [CNT_W-1:0]      r_frame_count;
  logic                  r_frame_done;
  logic                  r_timeout_err;

  logic                  w_fall;
  logic [IDX_W:0]        w_first;
  logic [IDX_W:0]        w_after;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_go;
  logic [IDX_W-1:0]      w_go_idx;

  // {found, index} of the lowest set bit of mask at or above lo
  function automatic logic [IDX_W:0] find_next(input logic [NUM_STAGES-1:0] mask,
                                               input int lo);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_STAGES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  vsync_edge_sync u_vsync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sync_n  (i_frame_sync),
    .o_fall    (w_fall)
  );

  assign w_first   = find_next(i_stage_enable, 0);
  assign w_after   = find_next(r_enable, int'(r_idx) + 1);
  assign w_done    = i_stage_done[r_idx];
  assign w_timeout = (TIMEOUT_CYCLES != '0) && (r_timer >= TIMEOUT_CYCLES - 1'b1);

  // Launch, relaunch and stage-to-stage handoff all funnel through w_go
  always_comb begin
    w_go     = 1'b0;
    w_go_idx = w_first[IDX_W-1:0];
    case (r_state)
      ST_IDLE: w_go = (i_run || i_single) && w_first[IDX_W];
      ST_RUN: begin
        if (w_done) begin
          if (w_after[IDX_W]) begin
            w_go     = 1'b1;
            w_go_idx = w_after[IDX_W-1:0];
          end else begin
            w_go = i_run && w_first[IDX_W];
          end
        end
      end
      default: w_go = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_enable      <= '0;
      r_stage_start <= '0;
      r_idx         <= '0;
      r_err_stage   <= '0;
      r_timer       <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_stage_start <= '0;
      r_frame_done  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_go) r_enable <= i_stage_enable;
        end
        ST_WAIT_SYNC: begin
          if (w_fall) begin
            r_state       <= ST_START;
            r_stage_start <= onehot(r_idx);
            r_timer       <= '0;
          end
        end
        ST_START: begin
          r_state <= ST_RUN;
          r_timer <= r_timer + 1'b1;
        end
        ST_RUN: begin
          if (w_done) begin
            if (!w_after[IDX_W]) begin
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 1'b1;
              if (i_run) r_enable <= i_stage_enable;
              if (!w_go) r_state <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_state       <= ST_ERROR;
            r_timeout_err <= 1'b1;
            r_err_stage   <= r_idx;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_ERROR: begin
          if (i_clear_err) begin
            r_state       <= ST_IDLE;
            r_timeout_err <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Placed after the case so a new stage selection overrides its state update
      if (w_go) begin
        r_idx <= w_go_idx;
        if (SYNC_MASK[w_go_idx]) begin
          r_state <= ST_WAIT_SYNC;
        end else begin
          r_state       <= ST_START;
          r_stage_start <= onehot(w_go_idx);
          r_timer       <= '0;
        end
      end
    end
  end

  assign o_stage_start = r_stage_start;
  assign o_stage_idx   = r_idx;
  assign o_state       = r_state;
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_ERROR);
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;
  assign o_timeout_err = r_timeout_err;
  assign o_err_stage   = r_err_stage;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench: dut A has no vsync gating and a 10-cycle watchdog, dut B gates
// stage 3 on vsync and uses a 2-bit frame counter to exercise wrap-around.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        run_a = 1'b0, single_a = 1'b0, clr_a = 1'b0;
  logic [3:0]  en_a = 4'b0, done_a = 4'b0;
  logic [3:0]  start_a;
  logic [1:0]  idx_a, estage_a;
  logic [2:0]  state_a;
  logic        busy_a, fd_a, terr_a;
  logic [15:0] cnt_a;

  logic        run_b = 1'b0, single_b = 1'b0, sync_b = 1'b1;
  logic [3:0]  en_b = 4'b0, done_b = 4'b0;
  logic [3:0]  start_b;
  logic [1:0]  idx_b, estage_b;
  logic [2:0]  state_b;
  logic        busy_b, fd_b, terr_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_start_a = 0;
  int base;

  always #5 clk = ~clk;

  always @(negedge clk) if (start_a != 4'b0) n_start_a++;

  pipeline_sequencer #(
    .NUM_STAGES(4), .SYNC_MASK(4'b0000), .TIMEOUT_CYCLES(24'd10), .CNT_W(16)
  ) u_dut_a (
    .i_clk(clk), .i_reset_n(reset_n), .i_run(run_a), .i_single(single_a),
    .i_clear_err(clr_a), .i_stage_enable(en_a), .i_frame_sync(1'b1),
    .i_stage_done(done_a), .o_stage_start(start_a), .o_stage_idx(idx_a),
    .o_state(state_a), .o_busy(busy_a), .o_frame_done(fd_a),
    .o_frame_count(cnt_a), .o_timeout_err(terr_a), .o_err_stage(estage_a)
  );

  pipeline_sequencer #(
    .NUM_STAGES(4), .SYNC_MASK(4'b1000), .TIMEOUT_CYCLES(24'd0), .CNT_W(2)
  ) u_dut_b (
    .i_clk(clk), .i_reset_n(reset_n), .i_run(run_b), .i_single(single_b),
    .i_clear_err(1'b0), .i_stage_enable(en_b), .i_frame_sync(sync_b),
    .i_stage_done(done_b), .o_stage_start(start_b), .o_stage_idx(idx_b),
    .o_state(state_b), .o_busy(busy_b), .o_frame_done(fd_b),
    .o_frame_count(cnt_b), .o_timeout_err(terr_b), .o_err_stage(estage_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  // called one cycle after a start pulse; done is sampled dly edges after that start
  task automatic finish_stage(input bit on_b, input int idx, input int dly);
    step(dly - 1);
    if (on_b) done_b = 4'(1 << idx);
    else      done_a = 4'(1 << idx);
    step(1);
    done_a = 4'b0;
    done_b = 4'b0;
  endtask

  initial begin
    // reset values
    step(3);
    chk("rst_state", state_a, 3'd0);
    chk("rst_start", start_a, 4'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_cnt", cnt_a, 16'd0);
    chk("rst_terr", terr_a, 1'b0);
    reset_n = 1'b1;
    step(1);

    // single frame through all four stages
    en_a = 4'b1111;
    base = n_start_a;
    single_a = 1'b1;
    step(1);
    single_a = 1'b0;
    chk("t1_launch_state", state_a, 3'd2);
    for (int i = 0; i < 4; i++) begin
      chk("t1_start_onehot", start_a, 32'(1 << i));
      chk("t1_stage_idx", idx_a, 32'(i));
      if (i == 1) begin
        single_a = 1'b1;
        step(1);
        single_a = 1'b0;
        finish_stage(1'b0, 1, 4);
      end else begin
        finish_stage(1'b0, i, 5);
      end
    end
    chk("t1_frame_done", fd_a, 1'b1);
    chk("t1_frame_count", cnt_a, 16'd1);
    chk("t1_end_state", state_a, 3'd0);
    chk("t1_end_busy", busy_a, 1'b0);
    step(1);
    chk("t1_fd_pulse", fd_a, 1'b0);
    chk("t1_start_total", n_start_a - base, 4);

    // continuous mode, sparse mask, mask change mid-frame
    do_reset();
    en_a = 4'b1010;
    base = n_start_a;
    run_a = 1'b1;
    step(1);
    chk("t2_f1_s1", start_a, 4'b0010);
    finish_stage(1'b0, 1, 5);
    chk("t2_f1_s3", start_a, 4'b1000);
    finish_stage(1'b0, 3, 5);
    chk("t2_f1_done", fd_a, 1'b1);
    chk("t2_f1_cnt", cnt_a, 16'd1);
    chk("t2_f2_s1", start_a, 4'b0010);
    en_a = 4'b0001;
    finish_stage(1'b0, 1, 5);
    chk("t2_f2_s3_latched", start_a, 4'b1000);
    finish_stage(1'b0, 3, 5);
    chk("t2_f2_done", fd_a, 1'b1);
    chk("t2_f2_cnt", cnt_a, 16'd2);
    chk("t2_f3_s0", start_a, 4'b0001);
    run_a = 1'b0;
    finish_stage(1'b0, 0, 5);
    chk("t2_f3_done", fd_a, 1'b1);
    chk("t2_f3_cnt", cnt_a, 16'd3);
    chk("t2_idle", state_a, 3'd0);
    chk("t2_start_total", n_start_a - base, 5);

    // watchdog: stage 1 never completes
    do_reset();
    en_a = 4'b1111;
    single_a = 1'b1;
    step(1);
    single_a = 1'b0;
    finish_stage(1'b0, 0, 5);
    chk("t4_s1_start", start_a, 4'b0010);
    step(9);
    chk("t4_still_run", state_a, 3'd3);
    chk("t4_no_err_yet", terr_a, 1'b0);
    step(1);
    chk("t4_error_state", state_a, 3'd4);
    chk("t4_terr", terr_a, 1'b1);
    chk("t4_err_stage", estage_a, 2'd1);
    chk("t4_err_busy", busy_a, 1'b0);
    single_a = 1'b1;
    step(1);
    single_a = 1'b0;
    step(2);
    chk("t4_err_hold", state_a, 3'd4);
    chk("t4_err_no_start", start_a, 4'b0);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("t4_clr_state", state_a, 3'd0);
    chk("t4_clr_terr", terr_a, 1'b0);
    chk("t4_err_stage_kept", estage_a, 2'd1);

    // done sampled on the same edge the watchdog would fire: done wins
    single_a = 1'b1;
    step(1);
    single_a = 1'b0;
    finish_stage(1'b0, 0, 10);
    chk("t5_next_state", state_a, 3'd2);
    chk("t5_next_start", start_a, 4'b0010);
    chk("t5_no_err", terr_a, 1'b0);
    finish_stage(1'b0, 1, 5);
    finish_stage(1'b0, 2, 5);
    finish_stage(1'b0, 3, 5);
    chk("t5_cnt", cnt_a, 16'd1);

    // reset asserted while stage 2 runs
    single_a = 1'b1;
    step(1);
    single_a = 1'b0;
    finish_stage(1'b0, 0, 5);
    finish_stage(1'b0, 1, 5);
    step(2);
    chk("t6_pre_state", state_a, 3'd3);
    chk("t6_pre_idx", idx_a, 2'd2);
    reset_n = 1'b0;
    #2;
    chk("t6_async_state", state_a, 3'd0);
    chk("t6_async_busy", busy_a, 1'b0);
    chk("t6_async_idx", idx_a, 2'd0);
    chk("t6_async_cnt", cnt_a, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = n_start_a;
    done_a = 4'b0100;
    step(20);
    done_a = 4'b0;
    chk("t6_no_start", n_start_a - base, 0);
    chk("t6_idle", state_a, 3'd0);

    // vsync-gated stage 3 on dut B
    do_reset();
    en_b = 4'b1111;
    single_b = 1'b1;
    step(1);
    single_b = 1'b0;
    chk("t3_s0_start", start_b, 4'b0001);
    sync_b = 1'b0;
    step(1);
    sync_b = 1'b1;
    finish_stage(1'b1, 0, 4);
    chk("t3_s1_start", start_b, 4'b0010);
    finish_stage(1'b1, 1, 5);
    finish_stage(1'b1, 2, 5);
    chk("t3_wait_sync", state_b, 3'd1);
    chk("t3_wait_no_start", start_b, 4'b0);
    chk("t3_wait_idx", idx_b, 2'd3);
    step(19);
    chk("t3_wait_hold", state_b, 3'd1);
    sync_b = 1'b0;
    step(2);
    chk("t3_fall_plus2", start_b, 4'b0);
    step(1);
    chk("t3_fall_plus3", start_b, 4'b1000);
    chk("t3_start_state", state_b, 3'd2);
    finish_stage(1'b1, 3, 5);
    sync_b = 1'b1;
    chk("t3_frame_done", fd_b, 1'b1);
    chk("t3_cnt", cnt_b, 2'd1);
    chk("t3_idle", state_b, 3'd0);

    // 2-bit frame counter wraps 3 -> 0
    en_b = 4'b0001;
    run_b = 1'b1;
    step(1);
    chk("t7_start", start_b, 4'b0001);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) run_b = 1'b0;
      finish_stage(1'b1, 0, 3);
      chk("t7_fd", fd_b, 1'b1);
      chk("t7_cnt", cnt_b, 32'((2 + f) % 4));
    end
    chk("t7_idle", state_b, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
